// File: rtl/mem_req_arbiter.sv
// Two-port memory request arbiter with a 16-entry tag table.
// Requests are granted round-robin and forwarded to memory with a tag that
// identifies the entry. Responses come back in any order and are routed to the
// original requester using that tag.
module mem_req_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_0,
    input  logic [DATA_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_data_0,
    input  logic              req_rw_0,
    input  logic [3:0]        req_id_0,
    output logic              grant_0,

    input  logic              req_valid_1,
    input  logic [DATA_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_data_1,
    input  logic              req_rw_1,
    input  logic [3:0]        req_id_1,
    output logic              grant_1,

    output logic [DATA_W-1:0] addr_out_M,
    output logic [DATA_W-1:0] data_out_M,
    output logic              rw_out_M,
    output logic [3:0]        ldstID_out_M,
    output logic              valid_out_M,
    input  logic              stall_in_M,

    input  logic              ready_in_M,
    input  logic [3:0]        ldstID_in_M,
    input  logic [DATA_W-1:0] data_in_M,

    output logic              resp_valid_0,
    output logic [3:0]        resp_id_0,
    output logic [DATA_W-1:0] resp_data_0,
    output logic              resp_valid_1,
    output logic [3:0]        resp_id_1,
    output logic [DATA_W-1:0] resp_data_1,

    output logic              busy,
    output logic              full,
    output logic              err_spurious
);

    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_e;

    logic [15:0] in_use;
    logic [15:0] tag_port;
    logic [3:0]  tag_orig_id [16];
    logic [4:0]  count;
    port_e       rr_ptr;

    logic        grant_any;
    logic [3:0]  alloc_tag;
    logic        release_valid;
    logic        release_port;

    assign full      = (count == 5'd16);
    assign busy      = (count != 5'd0);
    assign grant_any = grant_0 | grant_1;

    // Pick at most one port: the preferred one when both ask, otherwise the only asker.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!rst && !stall_in_M && !full) begin
            if (req_valid_0 && req_valid_1) begin
                if (rr_ptr == PORT_0) begin
                    grant_0 = 1'b1;
                end else begin
                    grant_1 = 1'b1;
                end
            end else if (req_valid_0) begin
                grant_0 = 1'b1;
            end else if (req_valid_1) begin
                grant_1 = 1'b1;
            end
        end
    end

    // Lowest free tag, from the registered table so a tag freed this cycle waits a cycle.
    always_comb begin
        logic found;
        alloc_tag = 4'd0;
        found     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!in_use[i] && !found) begin
                alloc_tag = 4'(i);
                found     = 1'b1;
            end
        end
    end

    // Decode the memory response against the tag table.
    always_comb begin
        release_valid = ready_in_M && in_use[ldstID_in_M];
        release_port  = tag_port[ldstID_in_M];
    end

    // Tag table: allocate on grant, free on a response for a live tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_use   <= '0;
            tag_port <= '0;
            for (int i = 0; i < 16; i++) begin
                tag_orig_id[i] <= 4'd0;
            end
        end else begin
            if (release_valid) begin
                in_use[ldstID_in_M] <= 1'b0;
            end
            if (grant_any) begin
                in_use[alloc_tag]      <= 1'b1;
                tag_port[alloc_tag]    <= grant_1;
                tag_orig_id[alloc_tag] <= grant_1 ? req_id_1 : req_id_0;
            end
        end
    end

    // Outstanding count; a simultaneous grant and release cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 5'd0;
        end else begin
            case ({grant_any, release_valid})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Move preference to the other port only once the preferred port was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= PORT_0;
        end else if ((rr_ptr == PORT_0 && grant_0) || (rr_ptr == PORT_1 && grant_1)) begin
            rr_ptr <= (rr_ptr == PORT_0) ? PORT_1 : PORT_0;
        end
    end

    // Sticky flag for responses that name a tag nobody is waiting on.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_spurious <= 1'b0;
        end else if (ready_in_M && !in_use[ldstID_in_M]) begin
            err_spurious <= 1'b1;
        end
    end

    // Register the granted request toward memory, tagged with its table entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_M  <= 1'b0;
            addr_out_M   <= '0;
            data_out_M   <= '0;
            rw_out_M     <= 1'b0;
            ldstID_out_M <= 4'd0;
        end else begin
            valid_out_M <= grant_any;
            if (grant_any) begin
                addr_out_M   <= grant_1 ? req_addr_1 : req_addr_0;
                data_out_M   <= grant_1 ? req_data_1 : req_data_0;
                rw_out_M     <= grant_1 ? req_rw_1   : req_rw_0;
                ldstID_out_M <= alloc_tag;
            end
        end
    end

    // Route a valid response to the recorded port; idle ports keep their last id/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_0 <= 1'b0;
            resp_id_0    <= 4'd0;
            resp_data_0  <= '0;
            resp_valid_1 <= 1'b0;
            resp_id_1    <= 4'd0;
            resp_data_1  <= '0;
        end else begin
            resp_valid_0 <= release_valid && !release_port;
            resp_valid_1 <= release_valid && release_port;
            if (release_valid && !release_port) begin
                resp_id_0   <= tag_orig_id[ldstID_in_M];
                resp_data_0 <= data_in_M;
            end
            if (release_valid && release_port) begin
                resp_id_1   <= tag_orig_id[ldstID_in_M];
                resp_data_1 <= data_in_M;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter. Inputs change 1 time unit after a
// rising edge; combinational grants are checked 1 unit later, registered
// outputs 1 unit after the next rising edge.
module tb_mem_req_arbiter;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              req_valid_0, req_valid_1;
    logic [DATA_W-1:0] req_addr_0, req_addr_1;
    logic [DATA_W-1:0] req_data_0, req_data_1;
    logic              req_rw_0, req_rw_1;
    logic [3:0]        req_id_0, req_id_1;
    logic              grant_0, grant_1;
    logic [DATA_W-1:0] addr_out_M, data_out_M;
    logic              rw_out_M;
    logic [3:0]        ldstID_out_M;
    logic              valid_out_M;
    logic              stall_in_M;
    logic              ready_in_M;
    logic [3:0]        ldstID_in_M;
    logic [DATA_W-1:0] data_in_M;
    logic              resp_valid_0, resp_valid_1;
    logic [3:0]        resp_id_0, resp_id_1;
    logic [DATA_W-1:0] resp_data_0, resp_data_1;
    logic              busy, full, err_spurious;

    int checks = 0;
    int errors = 0;

    mem_req_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_addr_0(req_addr_0), .req_data_0(req_data_0),
        .req_rw_0(req_rw_0), .req_id_0(req_id_0), .grant_0(grant_0),
        .req_valid_1(req_valid_1), .req_addr_1(req_addr_1), .req_data_1(req_data_1),
        .req_rw_1(req_rw_1), .req_id_1(req_id_1), .grant_1(grant_1),
        .addr_out_M(addr_out_M), .data_out_M(data_out_M), .rw_out_M(rw_out_M),
        .ldstID_out_M(ldstID_out_M), .valid_out_M(valid_out_M), .stall_in_M(stall_in_M),
        .ready_in_M(ready_in_M), .ldstID_in_M(ldstID_in_M), .data_in_M(data_in_M),
        .resp_valid_0(resp_valid_0), .resp_id_0(resp_id_0), .resp_data_0(resp_data_0),
        .resp_valid_1(resp_valid_1), .resp_id_1(resp_id_1), .resp_data_1(resp_data_1),
        .busy(busy), .full(full), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_0 = 0; req_addr_0 = '0; req_data_0 = '0; req_rw_0 = 0; req_id_0 = 0;
        req_valid_1 = 0; req_addr_1 = '0; req_data_1 = '0; req_rw_1 = 0; req_id_1 = 0;
        stall_in_M = 0; ready_in_M = 0; ldstID_in_M = 0; data_in_M = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        req_valid_0 = 1;
        #1;
        checks++; if (grant_0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0", grant_0); end
        tick();
        req_valid_0 = 0;
        checks++; if (valid_out_M !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_out: got %b expected 0", valid_out_M); end
        checks++; if (busy !== 1'b0 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_full: got %b%b expected 00", busy, full); end
        checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b%b expected 00", resp_valid_0, resp_valid_1); end
        checks++; if (addr_out_M !== '0 || ldstID_out_M !== 4'd0 || resp_data_0 !== '0) begin errors++; $display("[TB] FAIL reset_data: addr %h id %h rdata %h expected zeros", addr_out_M, ldstID_out_M, resp_data_0); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_spurious); end
        rst = 0;
    endtask

    task automatic test_single_load();
        do_reset();
        req_valid_0 = 1; req_addr_0 = 32'h40; req_id_0 = 4'd3; req_rw_0 = 0;
        #1;
        checks++; if (grant_0 !== 1'b1 || grant_1 !== 1'b0) begin errors++; $display("[TB] FAIL single_grant: got %b%b expected 10", grant_0, grant_1); end
        tick();
        req_valid_0 = 0;
        checks++; if (valid_out_M !== 1'b1 || ldstID_out_M !== 4'd0 || rw_out_M !== 1'b0) begin errors++; $display("[TB] FAIL single_issue: valid %b tag %0d rw %b expected 1 0 0", valid_out_M, ldstID_out_M, rw_out_M); end
        checks++; if (addr_out_M !== 32'h40) begin errors++; $display("[TB] FAIL single_addr: got %h expected 00000040", addr_out_M); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        ready_in_M = 1; ldstID_in_M = 4'd0; data_in_M = 32'hDEADBEEF;
        tick();
        ready_in_M = 0;
        checks++; if (resp_valid_0 !== 1'b1 || resp_id_0 !== 4'd3 || resp_data_0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_resp: valid %b id %0d data %h expected 1 3 deadbeef", resp_valid_0, resp_id_0, resp_data_0); end
        checks++; if (resp_valid_1 !== 1'b0 || valid_out_M !== 1'b0) begin errors++; $display("[TB] FAIL single_quiet: resp1 %b vout %b expected 0 0", resp_valid_1, valid_out_M); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: busy %b expected 0", busy); end
        tick();
        checks++; if (resp_valid_0 !== 1'b0 || resp_data_0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_hold: valid %b data %h expected 0 deadbeef", resp_valid_0, resp_data_0); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid_0 = 1; req_addr_0 = 32'hA000; req_id_0 = 4'd1;
        req_valid_1 = 1; req_addr_1 = 32'hB000; req_id_1 = 4'd2; req_rw_1 = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (grant_0 !== (i % 2 == 0) || grant_1 !== (i % 2 == 1)) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b%b expected %b%b", i, grant_0, grant_1, (i % 2 == 0), (i % 2 == 1)); end
            tick();
            checks++; if (ldstID_out_M !== i[3:0] || addr_out_M !== ((i % 2 == 0) ? 32'hA000 : 32'hB000)) begin errors++; $display("[TB] FAIL rr_tag%0d: tag %0d addr %h", i, ldstID_out_M, addr_out_M); end
        end
        req_valid_0 = 0; req_valid_1 = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid_0 = 1; req_id_0 = 4'd6;
        tick();
        req_valid_0 = 0;
        req_valid_1 = 1; req_id_1 = 4'd7;
        ready_in_M = 1; ldstID_in_M = 4'd0; data_in_M = 32'h0BAD_F00D;
        #1;
        checks++; if (grant_1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_grant: got %b expected 1", grant_1); end
        tick();
        req_valid_1 = 0; ready_in_M = 0;
        checks++; if (ldstID_out_M !== 4'd1) begin errors++; $display("[TB] FAIL b2b_no_reuse: tag %0d expected 1", ldstID_out_M); end
        checks++; if (resp_valid_0 !== 1'b1 || resp_id_0 !== 4'd6) begin errors++; $display("[TB] FAIL b2b_resp: valid %b id %0d expected 1 6", resp_valid_0, resp_id_0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_count: busy %b expected 1", busy); end
        req_valid_0 = 1;
        tick();
        req_valid_0 = 0;
        checks++; if (ldstID_out_M !== 4'd0) begin errors++; $display("[TB] FAIL b2b_reuse: tag %0d expected 0", ldstID_out_M); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        req_valid_0 = 1; req_id_0 = 4'd4;
        tick();
        req_id_0 = 4'd5;
        tick();
        req_valid_0 = 0;
        req_valid_1 = 1; req_id_1 = 4'd9;
        tick();
        req_valid_1 = 0;
        checks++; if (ldstID_out_M !== 4'd2) begin errors++; $display("[TB] FAIL ooo_setup: tag %0d expected 2", ldstID_out_M); end
        ready_in_M = 1; ldstID_in_M = 4'd2; data_in_M = 32'h2222_2222;
        tick();
        checks++; if (resp_valid_1 !== 1'b1 || resp_id_1 !== 4'd9 || resp_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL ooo_first: v1 %b id1 %0d v0 %b expected 1 9 0", resp_valid_1, resp_id_1, resp_valid_0); end
        ldstID_in_M = 4'd0; data_in_M = 32'h0000_4444;
        tick();
        ready_in_M = 0;
        checks++; if (resp_valid_0 !== 1'b1 || resp_id_0 !== 4'd4 || resp_data_0 !== 32'h0000_4444) begin errors++; $display("[TB] FAIL ooo_second: v0 %b id0 %0d data %h expected 1 4 00004444", resp_valid_0, resp_id_0, resp_data_0); end
        checks++; if (resp_valid_1 !== 1'b0 || resp_id_1 !== 4'd9) begin errors++; $display("[TB] FAIL ooo_hold: v1 %b id1 %0d expected 0 9", resp_valid_1, resp_id_1); end
    endtask

    // Runs straight after test_out_of_order: tag 1 (port 0, id 5) is still outstanding.
    task automatic test_stall();
        stall_in_M = 1;
        req_valid_0 = 1; req_id_0 = 4'd8;
        req_valid_1 = 1; req_id_1 = 4'd10;
        for (int i = 0; i < 3; i++) begin
            ready_in_M = (i == 1); ldstID_in_M = 4'd1; data_in_M = 32'h1234;
            #1;
            checks++; if (grant_0 !== 1'b0 || grant_1 !== 1'b0) begin errors++; $display("[TB] FAIL stall_grant%0d: got %b%b expected 00", i, grant_0, grant_1); end
            tick();
            checks++; if (valid_out_M !== 1'b0) begin errors++; $display("[TB] FAIL stall_vout%0d: got %b expected 0", i, valid_out_M); end
            if (i == 1) begin
                checks++; if (resp_valid_0 !== 1'b1 || resp_id_0 !== 4'd5 || resp_data_0 !== 32'h1234) begin errors++; $display("[TB] FAIL stall_resp: v %b id %0d data %h expected 1 5 00001234", resp_valid_0, resp_id_0, resp_data_0); end
            end
        end
        ready_in_M = 0; stall_in_M = 0;
        #1;
        checks++; if (grant_0 !== 1'b1 || grant_1 !== 1'b0) begin errors++; $display("[TB] FAIL stall_resume: got %b%b expected 10", grant_0, grant_1); end
        tick();
        req_valid_0 = 0; req_valid_1 = 0;
        checks++; if (valid_out_M !== 1'b1 || ldstID_out_M !== 4'd0) begin errors++; $display("[TB] FAIL stall_issue: v %b tag %0d expected 1 0", valid_out_M, ldstID_out_M); end
    endtask

    task automatic test_full();
        do_reset();
        req_valid_0 = 1;
        for (int i = 0; i < 16; i++) begin
            req_id_0 = i[3:0]; req_addr_0 = 32'h100 + i;
            #1;
            checks++; if (grant_0 !== 1'b1) begin errors++; $display("[TB] FAIL fill_grant%0d: got %b expected 1", i, grant_0); end
            tick();
            checks++; if (ldstID_out_M !== i[3:0]) begin errors++; $display("[TB] FAIL fill_tag%0d: got %0d expected %0d", i, ldstID_out_M, i); end
        end
        checks++; if (full !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: full %b busy %b expected 1 1", full, busy); end
        checks++; if (grant_0 !== 1'b0) begin errors++; $display("[TB] FAIL full_block: got %b expected 0", grant_0); end
        ready_in_M = 1; ldstID_in_M = 4'd5; data_in_M = 32'h55AA;
        #1;
        checks++; if (grant_0 !== 1'b0) begin errors++; $display("[TB] FAIL full_release_block: got %b expected 0", grant_0); end
        tick();
        ready_in_M = 0;
        checks++; if (full !== 1'b0 || valid_out_M !== 1'b0) begin errors++; $display("[TB] FAIL full_drop: full %b vout %b expected 0 0", full, valid_out_M); end
        checks++; if (resp_valid_0 !== 1'b1 || resp_id_0 !== 4'd5 || resp_data_0 !== 32'h55AA) begin errors++; $display("[TB] FAIL full_resp: v %b id %0d data %h expected 1 5 000055aa", resp_valid_0, resp_id_0, resp_data_0); end
        req_id_0 = 4'd12;
        #1;
        checks++; if (grant_0 !== 1'b1) begin errors++; $display("[TB] FAIL refill_grant: got %b expected 1", grant_0); end
        tick();
        req_valid_0 = 0;
        checks++; if (ldstID_out_M !== 4'd5 || full !== 1'b1) begin errors++; $display("[TB] FAIL refill_tag: tag %0d full %b expected 5 1", ldstID_out_M, full); end
    endtask

    task automatic test_spurious();
        do_reset();
        req_valid_0 = 1; req_id_0 = 4'd2;
        tick();
        req_valid_0 = 0;
        ready_in_M = 1; ldstID_in_M = 4'd7; data_in_M = 32'h7777;
        tick();
        ready_in_M = 0;
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("[TB] FAIL spur_flag: got %b expected 1", err_spurious); end
        checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL spur_no_resp: got %b%b expected 00", resp_valid_0, resp_valid_1); end
        checks++; if (busy !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL spur_count: busy %b full %b expected 1 0", busy, full); end
        tick();
        tick();
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("[TB] FAIL spur_sticky: got %b expected 1", err_spurious); end
        do_reset();
        checks++; if (err_spurious !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL spur_reset: err %b busy %b expected 0 0", err_spurious, busy); end
        ready_in_M = 1; ldstID_in_M = 4'd0; data_in_M = 32'h0;
        tick();
        ready_in_M = 0;
        checks++; if (err_spurious !== 1'b1 || resp_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL spur_discarded: err %b v0 %b expected 1 0", err_spurious, resp_valid_0); end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_load();
        test_round_robin();
        test_back_to_back();
        test_out_of_order();
        test_stall();
        test_full();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
